// File: rtl/cpu7_ifu_fctl_pkg.sv
// Shared IFU definitions: fetch-control FSM encoding, the default depth of
// the outstanding-request window and a small saturating-counter helper.
package cpu7_ifu_fctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fctl_state_e;

  // Accepted-but-unreturned fetch requests allowed at once (legal 1..3).
  localparam int IFU_MAX_OUTSTD = 2;

  // Decrement that sticks at zero; a stray response must never wrap a count.
  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/cpu7_ifu_fbuf.sv
// Small in-order instruction buffer. Push appends at the tail, pop removes
// the head, flush empties everything in one cycle (flush wins over push/pop).
// Head is a registered array read, so it is valid only while count != 0.
module cpu7_ifu_fbuf #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count < CW'(DEPTH)) | pop_ok);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop_ok) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/cpu7_ifu_fctl.sv
// Instruction-fetch flow control. Issues fetch requests to the memory side,
// tracks how many are in flight, drops responses that belong to requests
// made before a redirect, and buffers live instructions for decode.
//
// Handshakes: a request transfers in a cycle where inst_req & inst_addr_ok;
// responses come back strictly in request order, one per inst_valid_raw
// cycle, with no back-pressure. Toward decode, fetch_valid_f marks the head
// instruction and it is consumed in the same cycle unless redirect is high.
//
// live_cnt counts in-flight requests whose data is still wanted; drop_cnt
// counts in-flight requests issued before a redirect. Because responses are
// in order, all dropped ones return before any live one.
module cpu7_ifu_fctl
  import cpu7_ifu_fctl_pkg::*;
#(
  parameter int MAX_OUTSTD = IFU_MAX_OUTSTD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic [31:0] pc_req,
  input  logic        redirect,
  input  logic        stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_valid_raw,
  input  logic [31:0] inst_rdata_raw,
  output logic        inst_cancel,
  output logic        pc_adv,
  output logic        fetch_valid_f,
  output logic [31:0] fetch_inst_f,
  output fctl_state_e dbg_state
);

  localparam int CW = $clog2(MAX_OUTSTD + 1);

  fctl_state_e   state;
  logic [1:0]    live_cnt;
  logic [1:0]    drop_cnt;
  logic [1:0]    live_nxt;
  logic [1:0]    drop_nxt;
  logic [1:0]    drop_sum;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic [31:0]   fifo_head;
  logic [3:0]    inflight;
  logic          active;
  logic          accept;
  logic          resp;
  logic          redir;
  logic          push;
  logic          pop;

  assign active   = (state != IDLE);
  // Registered counts only: a slot freed this cycle is reusable next cycle.
  assign inflight = 4'(live_cnt) + 4'(drop_cnt) + 4'(fifo_cnt);
  assign inst_req = active & fetch_en & (inflight < 4'(MAX_OUTSTD));
  assign inst_addr = pc_req;
  assign accept   = inst_req & inst_addr_ok;
  assign pc_adv   = accept;

  assign redir       = active & redirect;
  assign inst_cancel = redir;
  assign resp        = active & inst_valid_raw;

  // Keep only responses for wanted requests; a redirect kills this one too.
  assign push = resp & ~redir & (drop_cnt == 2'd0) & (live_cnt != 2'd0);

  assign fetch_valid_f = active & ~fifo_empty & ~stall;
  assign pop           = fetch_valid_f & ~redir;
  assign fetch_inst_f  = active ? fifo_head : 32'h0;
  assign dbg_state     = state;

  // drop+live never exceeds 3, so the two-bit sum cannot wrap.
  assign drop_sum = drop_cnt + live_cnt;

  // Next-count logic for accept, response and redirect events.
  always_comb begin
    live_nxt = live_cnt;
    drop_nxt = drop_cnt;
    if (redir) begin
      // Everything in flight becomes stale except a request accepted now,
      // which was already issued to the redirect target.
      drop_nxt = resp ? sat_dec(drop_sum) : drop_sum;
      live_nxt = accept ? 2'd1 : 2'd0;
    end else begin
      if (resp) begin
        if (drop_cnt != 2'd0) drop_nxt = drop_cnt - 2'd1;
        else                  live_nxt = sat_dec(live_cnt);
      end
      if (accept) live_nxt = live_nxt + 2'd1;
    end
  end

  // FSM and counters: IDLE leaves on the first edge after reset; afterwards
  // FLUSH simply mirrors whether stale responses are still expected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      live_cnt <= 2'd0;
      drop_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        default: begin
          live_cnt <= live_nxt;
          drop_cnt <= drop_nxt;
          state    <= (drop_nxt != 2'd0) ? FLUSH : RUN;
        end
      endcase
    end
  end

  cpu7_ifu_fbuf #(
    .DEPTH (MAX_OUTSTD),
    .WIDTH (32)
  ) u_fbuf (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (inst_rdata_raw),
    .count (fifo_cnt),
    .head  (fifo_head),
    .empty (fifo_empty)
  );

endmodule
